// File: rtl/mult_div_unit.sv
// Multi-cycle RV32M multiply/divide responder for the execute stage.
// One request is accepted per transaction over req/gnt; the 32-bit result is
// returned over rvalid/rready and held stable until the transfer.
//
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset
//   req_i/gnt_o  request handshake; accept when req_i && gnt_o
//   op_i         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   operand_a_i  rs1 value, operand_b_i rs2 value
//   result_o     result, reads 0 outside the DONE state
//   rvalid_o     result valid; rready_i consumer ready
//   flush_i      abort any in-flight operation, no result is delivered
//   busy_o       unit not idle
module mult_div_unit #(
  // Cycles spent in MUL before the result is ready; legal range 1..4.
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic        flush_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;      // op[2] is implied by the state
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quot_q, quot_d;  // dividend shifts out as quotient shifts in
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] result_q, result_d;

  // Multiply: 33x33 signed product, computed mod 2^64.
  logic        mul_a_sgn, mul_b_sgn;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_a_sgn = (op_q != 2'b11) & a_q[31];
  assign mul_b_sgn = ~op_q[1] & b_q[31];
  assign mul_a     = {{32{mul_a_sgn}}, a_q};
  assign mul_b     = {{32{mul_b_sgn}}, b_q};
  assign prod      = mul_a * mul_b;

  // Restoring divide step: one quotient bit per cycle.
  logic [32:0] rem_shift, rem_diff;
  logic        q_bit;
  logic [31:0] rem_step, quot_step;
  logic        neg_quot, neg_rem;

  assign rem_shift = {rem_q, quot_q[31]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign q_bit     = ~rem_diff[32];
  assign rem_step  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
  assign quot_step = {quot_q[30:0], q_bit};
  assign neg_quot  = ~op_q[0] & (a_q[31] ^ b_q[31]);
  assign neg_rem   = ~op_q[0] & a_q[31];

  // Accept-time decode of divide operands and special cases.
  logic        in_signed, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b;

  assign in_signed = ~op_i[0];
  assign abs_a     = (in_signed & operand_a_i[31]) ? (~operand_a_i + 32'd1) : operand_a_i;
  assign abs_b     = (in_signed & operand_b_i[31]) ? (~operand_b_i + 32'd1) : operand_b_i;
  assign div_zero  = (operand_b_i == 32'd0);
  assign div_ovf   = in_signed & (operand_a_i == 32'h8000_0000) &
                     (operand_b_i == 32'hFFFF_FFFF);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    gnt_o     = (state_q == StIdle) && !flush_i;

    unique case (state_q)
      StIdle: begin
        if (req_i && gnt_o) begin
          op_d = op_i[1:0];
          a_d  = operand_a_i;
          b_d  = operand_b_i;
          if (!op_i[2]) begin
            state_d = StMul;
            cnt_d   = 5'(MUL_LAT - 1);
          end else if (div_zero) begin
            state_d  = StDone;
            result_d = op_i[1] ? operand_a_i : 32'hFFFF_FFFF;
          end else if (div_ovf) begin
            state_d  = StDone;
            result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d   = StDiv;
            cnt_d     = 5'd31;
            quot_d    = abs_a;
            rem_d     = 32'd0;
            divisor_d = abs_b;
          end
        end
      end
      StMul: begin
        if (cnt_q == 5'd0) begin
          state_d  = StDone;
          result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StDiv: begin
        quot_d = quot_step;
        rem_d  = rem_step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StDone;
          if (op_q[1]) begin
            result_d = neg_rem ? (~rem_step + 32'd1) : rem_step;
          end else begin
            result_d = neg_quot ? (~quot_step + 32'd1) : quot_step;
          end
        end
      end
      StDone: begin
        if (rready_i) begin
          state_d  = StIdle;
          result_d = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over completion and over the consumer handshake.
    if (flush_i) begin
      state_d  = StIdle;
      result_d = 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      quot_q    <= 32'd0;
      rem_q     <= 32'd0;
      divisor_q <= 32'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
    end
  end

  assign rvalid_o = (state_q == StDone);
  assign result_o = (state_q == StDone) ? result_q : 32'd0;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed vectors.
module tb_mult_div_unit;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] operand_a_i = 32'd0;
  logic [31:0] operand_b_i = 32'd0;
  logic [31:0] result_o;
  logic        rvalid_o;
  logic        rready_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.MUL_LAT(1)) u_dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .result_o    (result_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge of cycle T+1.
  task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk_i);
    req_i       = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    #1;
    check_eq({tag, "_gnt"}, {31'd0, gnt_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    req_i       = 1'b0;
    op_i        = $urandom_range(7, 0);
    operand_a_i = $urandom;
    operand_b_i = $urandom;
  endtask

  // Count cycles from T until rvalid_o, bounded, then check latency and value.
  task automatic wait_valid(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int cyc = 1;
    while (!rvalid_o && cyc < 100) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, exp_lat);
    check_eq({tag, "_res"}, result_o, exp_res);
  endtask

  // Full transaction with rready_i held high; checks the unit drains.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    start_op(tag, op, a, b);
    wait_valid(tag, exp_lat, exp_res);
    @(negedge clk_i);
    check_eq({tag, "_idle"}, {30'd0, busy_o, rvalid_o}, 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check_eq("rst_outs", {29'd0, rvalid_o, busy_o, gnt_o}, 32'd1);
    check_eq("rst_result", result_o, 32'd0);
    rst_n_i = 1'b1;

    // Multiply: latency T+1+MUL_LAT.
    run_op("mul_7x-3",   OpMul,    32'd7,         32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
    check_eq("result_zero_idle", result_o, 32'd0);
    run_op("mulh_min",   OpMulh,   32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
    run_op("mulhsu_min", OpMulhsu, 32'h8000_0000, 32'h8000_0000, 2, 32'hC000_0000);
    run_op("mulhu_min",  OpMulhu,  32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
    run_op("mulhu_ones", OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    run_op("mulh_ones",  OpMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000);
    run_op("mulhsu_ones", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);

    // Divide: latency T+33.
    run_op("div_-20_3",  OpDiv,  32'hFFFF_FFEC, 32'd3,         33, 32'hFFFF_FFFA);
    run_op("rem_-20_3",  OpRem,  32'hFFFF_FFEC, 32'd3,         33, 32'hFFFF_FFFE);
    run_op("divu_max_2", OpDivu, 32'hFFFF_FFFF, 32'd2,         33, 32'h7FFF_FFFF);
    run_op("remu_max_2", OpRemu, 32'hFFFF_FFFF, 32'd2,         33, 32'h0000_0001);
    run_op("div_100_7",  OpDiv,  32'd100,       32'd7,         33, 32'd14);
    run_op("rem_100_7",  OpRem,  32'd100,       32'd7,         33, 32'd2);
    run_op("div_7_-2",   OpDiv,  32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_op("rem_7_-2",   OpRem,  32'd7,         32'hFFFF_FFFE, 33, 32'd1);
    run_op("divu_min_m1", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

    // Special cases: latency T+1.
    run_op("divu_by0",  OpDivu, 32'd5,         32'd0,         1, 32'hFFFF_FFFF);
    run_op("rem_by0",   OpRem,  32'd5,         32'd0,         1, 32'd5);
    run_op("div_ovf",   OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf",   OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // Backpressure in DONE.
    rready_i = 1'b0;
    start_op("bp", OpMul, 32'd6, 32'd9);
    wait_valid("bp", 2, 32'd54);
    seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!rvalid_o || result_o != 32'd54 || gnt_o) seen++;
    end
    check_eq("bp_stable", seen, 0);
    rready_i = 1'b1;
    @(negedge clk_i);
    check_eq("bp_release", {30'd0, rvalid_o, gnt_o}, 32'd1);

    // Flush mid-divide at T+10.
    start_op("fl", OpDiv, 32'd1000, 32'd3);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq("fl_idle", {30'd0, busy_o, rvalid_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (rvalid_o) seen++;
    end
    check_eq("fl_no_valid", seen, 0);

    // Flush while requesting in IDLE: no grant, no accept.
    @(negedge clk_i);
    req_i   = 1'b1;
    op_i    = OpMul;
    flush_i = 1'b1;
    #1;
    check_eq("fl_no_gnt", {31'd0, gnt_o}, 32'd0);
    @(negedge clk_i);
    req_i   = 1'b0;
    flush_i = 1'b0;
    check_eq("fl_no_accept", {31'd0, busy_o}, 32'd0);
    run_op("mul_after_fl", OpMul, 32'd12, 32'd11, 2, 32'd132);

    // Synchronous reset mid-divide at T+5.
    start_op("rs", OpDivu, 32'd1000, 32'd3);
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_eq("rs_idle", {29'd0, busy_o, rvalid_o, gnt_o}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (rvalid_o) seen++;
    end
    check_eq("rs_no_valid", seen, 0);
    run_op("mul_after_rs", OpMul, 32'hFFFF_FFFF, 32'd5, 2, 32'hFFFF_FFFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
